// File: rtl/instr_fetch_responder.sv
// Instruction-fetch responder: accepts one fetch at a time, returns the stored word after
// WAIT_STATES cycles, or a NOP tagged with a fault cause for misaligned/out-of-range addresses.
module instr_fetch_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fetch_req,
  input  logic [31:0]                    iaddr,
  output logic                           fetch_ready,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [31:0]                    instr,
  output logic [1:0]                     fault_cause,
  output logic [31:0]                    fetch_count,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [1:0]  IDLE      = 2'd0;
  localparam logic [1:0]  WAIT      = 2'd1;
  localparam logic [1:0]  RESP      = 2'd2;
  localparam logic [3:0]  WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [AW-1:0] word_idx;

  logic          misaligned;
  logic          below_base;
  logic          out_of_range;
  logic [30:0]   off_words;

  // Word offset computed with a spare top bit so addresses far above the store never wrap back in.
  assign misaligned   = |iaddr[1:0];
  assign below_base   = iaddr < BASE_ADDR;
  assign off_words    = {1'b0, iaddr[31:2]} - {1'b0, BASE_ADDR[31:2]};
  assign out_of_range = below_base || (off_words >= 31'(DEPTH_WORDS));

  assign fetch_ready = (state == IDLE) && !reset;
  assign resp_valid  = (state == RESP);

  // No reset here: program contents survive reset, and loads are honoured in every state.
  always_ff @(posedge clk) begin
    if (load_en)
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      word_idx    <= '0;
      instr       <= NOP;
      fault_cause <= 2'd0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_req) begin
            word_idx <= off_words[AW-1:0];
            if (misaligned) begin
              instr       <= NOP;
              fault_cause <= 2'd1;
              state       <= RESP;
            end else if (out_of_range) begin
              instr       <= NOP;
              fault_cause <= 2'd2;
              state       <= RESP;
            end else begin
              fault_cause <= 2'd0;
              if (WAIT_STATES == 0) begin
                instr <= mem[off_words[AW-1:0]];
                state <= RESP;
              end else begin
                cnt   <= WAIT_INIT;
                state <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            instr <= mem[word_idx];
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            fetch_count <= fetch_count + 32'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboard bench: instance a (WAIT_STATES=1) covers faults, stalls, reset and read-before-write;
// instance b (WAIT_STATES=0) covers back-to-back streaming. Both share the load port.
module tb_instr_fetch_responder;

  localparam int DW = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, resp_ready;
  logic [31:0] iaddr;
  logic        fetch_ready, resp_valid;
  logic [31:0] instr, fetch_count;
  logic [1:0]  fault_cause;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  logic        b_fetch_req, b_resp_ready;
  logic [31:0] b_iaddr;
  logic        b_fetch_ready, b_resp_valid;
  logic [31:0] b_instr, b_fetch_count;
  logic [1:0]  b_fault_cause;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_count;
  logic [31:0] model [DW];
  logic [33:0] expq[$];
  logic [33:0] bq[$];

  always #5 clk = ~clk;

  instr_fetch_responder #(.DEPTH_WORDS(DW), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut_a (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .iaddr(iaddr),
    .fetch_ready(fetch_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .instr(instr), .fault_cause(fault_cause), .fetch_count(fetch_count),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  instr_fetch_responder #(.DEPTH_WORDS(DW), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset), .fetch_req(b_fetch_req), .iaddr(b_iaddr),
    .fetch_ready(b_fetch_ready), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .instr(b_instr), .fault_cause(b_fault_cause), .fetch_count(b_fetch_count),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic loadWord(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    load_en = 1'b1; load_addr = idx; load_data = data;
    model[idx] = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Issue one fetch on instance a and wait for its response; optionally collide a load with the read.
  task automatic applyStimulus(input logic [31:0] addr, input bit do_load,
                               input logic [7:0] lidx, input logic [31:0] ldata);
    logic [1:0]  cause;
    logic [31:0] exp_instr;
    logic [33:0] e;
    int          lat;
    cause     = (addr[1:0] != 2'b00) ? 2'd1 : (addr >= 32'(4 * DW)) ? 2'd2 : 2'd0;
    exp_instr = (cause != 2'd0) ? 32'h0000_0013 : model[addr[9:2]];
    @(negedge clk);
    checkOutput("ready_idle", 32'(fetch_ready), 32'd1);
    fetch_req = 1'b1; iaddr = addr;
    expq.push_back({cause, exp_instr});
    @(negedge clk);
    fetch_req = 1'b0;
    if (do_load) begin
      load_en = 1'b1; load_addr = lidx; load_data = ldata;
      model[lidx] = ldata;
    end
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      load_en = 1'b0;
      lat++;
    end
    load_en = 1'b0;
    if (lat >= 20) begin
      checkOutput("resp_timeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("latency", 32'(lat), (cause != 2'd0) ? 32'd0 : 32'd1);
    checkOutput("ready_busy", 32'(fetch_ready), 32'd0);
    if (expq.size() == 0) begin
      checkOutput("unexpected_resp", 32'd1, 32'd0);
    end else begin
      e = expq.pop_front();
      checkOutput("instr", instr, e[31:0]);
      checkOutput("cause", 32'(fault_cause), 32'(e[33:32]));
    end
  endtask

  task automatic consume(input int hold, input logic [31:0] exp_instr);
    resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(resp_valid), 32'd1);
      checkOutput("hold_instr", instr, exp_instr);
      checkOutput("hold_ready", 32'(fetch_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    checkOutput("count", fetch_count, exp_count);
    checkOutput("ready_after", 32'(fetch_ready), 32'd1);
    checkOutput("valid_after", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [33:0] e;
    int cyc, last, nresp, issued;
    reset = 1'b1; fetch_req = 1'b0; iaddr = '0; resp_ready = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    b_fetch_req = 1'b0; b_iaddr = '0; b_resp_ready = 1'b1;
    exp_count = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(fetch_ready), 32'd0);
    checkOutput("rst_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'h0000_0013);
    checkOutput("rst_cause", 32'(fault_cause), 32'd0);
    checkOutput("rst_count", fetch_count, 32'd0);
    loadWord(8'd0, 32'h0050_0F93);
    loadWord(8'd1, 32'h0000_0013);
    loadWord(8'd2, 32'h1234_5678);
    loadWord(8'd3, 32'h0010_0093);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rel_ready", 32'(fetch_ready), 32'd1);

    applyStimulus(32'h0000_0000, 1'b0, 8'd0, 32'd0);  consume(0, 32'h0050_0F93);
    applyStimulus(32'h0000_0006, 1'b0, 8'd0, 32'd0);  consume(0, 32'h0000_0013);
    applyStimulus(32'h0000_0400, 1'b0, 8'd0, 32'd0);  consume(0, 32'h0000_0013);
    applyStimulus(32'hFFFF_FFFC, 1'b0, 8'd0, 32'd0);  consume(0, 32'h0000_0013);
    applyStimulus(32'h0000_03FC, 1'b0, 8'd0, 32'd0);  consume(0, model[255]);

    // Stall in RESP while a second request is pending; it must be taken one cycle after consume.
    applyStimulus(32'h0000_0000, 1'b0, 8'd0, 32'd0);
    fetch_req = 1'b1; iaddr = 32'h0000_0006;
    expq.push_back({2'd1, 32'h0000_0013});
    consume(5, 32'h0050_0F93);
    @(negedge clk);
    fetch_req = 1'b0;
    checkOutput("next_accept_valid", 32'(resp_valid), 32'd1);
    checkOutput("next_accept_ready", 32'(fetch_ready), 32'd0);
    if (expq.size() == 0) checkOutput("unexpected_resp", 32'd1, 32'd0);
    else begin
      e = expq.pop_front();
      checkOutput("next_instr", instr, e[31:0]);
      checkOutput("next_cause", 32'(fault_cause), 32'(e[33:32]));
    end
    consume(0, 32'h0000_0013);

    // Reset while a valid fetch sits in WAIT.
    @(negedge clk);
    fetch_req = 1'b1; iaddr = 32'h0000_0004;
    @(negedge clk);
    fetch_req = 1'b0;
    checkOutput("wait_valid", 32'(resp_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("wrst_ready", 32'(fetch_ready), 32'd0);
    checkOutput("wrst_count", fetch_count, 32'd0);
    checkOutput("wrst_instr", instr, 32'h0000_0013);
    exp_count = 32'd0;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("wrst_rel_ready", 32'(fetch_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("wrst_no_resp", 32'(resp_valid), 32'd0);
    end

    applyStimulus(32'h0000_0008, 1'b1, 8'd2, 32'hDEAD_BEEF);  consume(0, 32'h1234_5678);
    applyStimulus(32'h0000_0008, 1'b0, 8'd0, 32'd0);          consume(0, 32'hDEAD_BEEF);

    // Zero-wait-state instance: stream four fetches with resp_ready held high.
    cyc = 0; last = -1; nresp = 0; issued = 0;
    while (nresp < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (b_resp_valid) begin
        if (bq.size() == 0) checkOutput("b_unexpected", 32'd1, 32'd0);
        else begin
          e = bq.pop_front();
          checkOutput("b_instr", b_instr, e[31:0]);
          checkOutput("b_cause", 32'(b_fault_cause), 32'(e[33:32]));
        end
        if (last >= 0) checkOutput("b_gap", 32'(cyc - last), 32'd2);
        last = cyc;
        nresp++;
      end
      if (b_fetch_ready && issued < 4) begin
        b_fetch_req = 1'b1;
        b_iaddr = 32'(issued * 4);
        bq.push_back({2'd0, model[issued]});
        issued++;
      end else begin
        b_fetch_req = 1'b0;
      end
    end
    if (nresp < 4) checkOutput("b_timeout", 32'(nresp), 32'd4);
    @(negedge clk);
    b_fetch_req = 1'b0;
    checkOutput("b_count", b_fetch_count, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
